iserdes_rdlvl_seq: RTL and testbench



---
 rtl/iserdes_rdlvl_pkg.sv | 19 +
 rtl/rdlvl_window_track.sv | 58 +++++
 rtl/iserdes_rdlvl_seq.sv | 175 +++++++++++++++++
 tb/tb_iserdes_rdlvl_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/iserdes_rdlvl_pkg.sv
// Shared types and constants for the ISERDES read-leveling sequencer.
// Optional build macro ISERDES_RDLVL_INV_RETRY_EN is consumed by iserdes_rdlvl_seq.
package iserdes_rdlvl_pkg;

    localparam int         TAP_W           = 5;
    localparam logic [3:0] EXP_PATTERN_DEF = 4'b0101;

    typedef enum logic [2:0] {
        IDLE,
        SET,
        SETTLE,
        SAMPLE,
        EVAL,
        NEXT,
        CALC,
        APPLY
    } rdlvl_state_t;

endpackage

// File: rtl/rdlvl_window_track.sv
// Tracks the longest contiguous run of passing taps in a pass/fail stream.
// Ties keep the earliest run; a run ending at the last tap simply closes.
module rdlvl_window_track #(
    parameter int TAP_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 valid,
    input  logic                 pass,
    input  logic [TAP_WIDTH-1:0] tap,
    output logic [TAP_WIDTH-1:0] best_start,
    output logic [TAP_WIDTH:0]   best_len
);

    logic [TAP_WIDTH-1:0] cur_start_reg, cur_start_next;
    logic [TAP_WIDTH:0]   cur_len_reg, cur_len_next;
    logic [TAP_WIDTH-1:0] best_start_reg, best_start_next;
    logic [TAP_WIDTH:0]   best_len_reg, best_len_next;

    always_comb begin
        cur_start_next  = cur_start_reg;
        cur_len_next    = cur_len_reg;
        best_start_next = best_start_reg;
        best_len_next   = best_len_reg;
        if (valid) begin
            if (pass) begin
                cur_start_next = (cur_len_reg == '0) ? tap : cur_start_reg;
                cur_len_next   = cur_len_reg + (TAP_WIDTH+1)'(1);
                // Strictly greater, so an equal later run never displaces the earlier one.
                if (cur_len_next > best_len_reg) begin
                    best_start_next = cur_start_next;
                    best_len_next   = cur_len_next;
                end
            end else begin
                cur_len_next = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cur_start_reg  <= '0;
            cur_len_reg    <= '0;
            best_start_reg <= '0;
            best_len_reg   <= '0;
        end else begin
            cur_start_reg  <= cur_start_next;
            cur_len_reg    <= cur_len_next;
            best_start_reg <= best_start_next;
            best_len_reg   <= best_len_next;
        end
    end

    assign best_start = best_start_reg;
    assign best_len   = best_len_reg;

endmodule

// File: rtl/iserdes_rdlvl_seq.sv
// Read-leveling sequencer: sweeps IDELAY taps, finds the widest passing window, loads its centre.
// Define ISERDES_RDLVL_INV_RETRY_EN to retry a failed sweep with CLKDIV inverted.
module iserdes_rdlvl_seq
    import iserdes_rdlvl_pkg::*;
#(
    parameter int         TAP_WIDTH   = TAP_W,
    parameter int         SETTLE_CYC  = 8,
    parameter int         NUM_SAMPLES = 16,
    parameter logic [3:0] EXP_PATTERN = EXP_PATTERN_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [3:0]           dout,
    output logic [TAP_WIDTH-1:0] dly_tap,
    output logic                 dly_ld,
    output logic                 inv_clk_div,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [TAP_WIDTH-1:0] best_tap,
    output logic [TAP_WIDTH:0]   win_len
);

    localparam logic [7:0]           SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [7:0]           SAMPLE_LAST = 8'(NUM_SAMPLES - 1);
    localparam logic [TAP_WIDTH-1:0] TAP_MAX     = '1;

    rdlvl_state_t         state_reg;
    logic [TAP_WIDTH-1:0] tap_reg;
    logic [7:0]           cnt_reg;
    logic                 err_reg;

    logic                 trk_clear;
    logic [TAP_WIDTH-1:0] trk_best_start;
    logic [TAP_WIDTH:0]   trk_best_len;
    logic [TAP_WIDTH:0]   half_len;
    logic [TAP_WIDTH-1:0] centre_tap;
    logic                 retry_sweep;

`ifdef ISERDES_RDLVL_INV_RETRY_EN
    assign retry_sweep = ~inv_clk_div;
`else
    assign retry_sweep = 1'b0;
    assign inv_clk_div = 1'b0;
`endif

    // best_len <= 2^TAP_WIDTH, so half of (len-1) always fits in TAP_WIDTH bits.
    assign half_len   = (trk_best_len - (TAP_WIDTH+1)'(1)) >> 1;
    assign centre_tap = trk_best_start + half_len[TAP_WIDTH-1:0];

    assign trk_clear = ((state_reg == IDLE) && start) ||
                       ((state_reg == CALC) && (trk_best_len == '0) && retry_sweep);

    rdlvl_window_track #(
        .TAP_WIDTH (TAP_WIDTH)
    ) u_window_track (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (trk_clear),
        .valid      (state_reg == EVAL),
        .pass       (~err_reg),
        .tap        (tap_reg),
        .best_start (trk_best_start),
        .best_len   (trk_best_len)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            tap_reg     <= '0;
            cnt_reg     <= '0;
            err_reg     <= 1'b0;
            dly_tap     <= '0;
            dly_ld      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
            best_tap    <= '0;
            win_len     <= '0;
`ifdef ISERDES_RDLVL_INV_RETRY_EN
            inv_clk_div <= 1'b0;
`endif
        end else begin
            dly_ld <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        tap_reg     <= '0;
                        cnt_reg     <= '0;
                        err_reg     <= 1'b0;
                        done        <= 1'b0;
                        fail        <= 1'b0;
                        busy        <= 1'b1;
                        best_tap    <= '0;
                        win_len     <= '0;
`ifdef ISERDES_RDLVL_INV_RETRY_EN
                        inv_clk_div <= 1'b0;
`endif
                        state_reg   <= SET;
                    end
                end
                SET: begin
                    dly_tap   <= tap_reg;
                    dly_ld    <= 1'b1;
                    cnt_reg   <= '0;
                    state_reg <= SETTLE;
                end
                SETTLE: begin
                    if (cnt_reg == SETTLE_LAST) begin
                        cnt_reg   <= '0;
                        err_reg   <= 1'b0;
                        state_reg <= SAMPLE;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                SAMPLE: begin
                    if (dout != EXP_PATTERN) begin
                        err_reg <= 1'b1;
                    end
                    if (cnt_reg == SAMPLE_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= EVAL;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                EVAL: begin
                    state_reg <= NEXT;
                end
                NEXT: begin
                    if (tap_reg == TAP_MAX) begin
                        state_reg <= CALC;
                    end else begin
                        tap_reg   <= tap_reg + TAP_WIDTH'(1);
                        state_reg <= SET;
                    end
                end
                CALC: begin
                    if (trk_best_len == '0) begin
                        if (retry_sweep) begin
`ifdef ISERDES_RDLVL_INV_RETRY_EN
                            inv_clk_div <= 1'b1;
`endif
                            tap_reg   <= '0;
                            state_reg <= SET;
                        end else begin
                            fail      <= 1'b1;
                            busy      <= 1'b0;
                            dly_tap   <= '0;
                            dly_ld    <= 1'b1;
                            state_reg <= IDLE;
                        end
                    end else begin
                        best_tap  <= centre_tap;
                        win_len   <= trk_best_len;
                        state_reg <= APPLY;
                    end
                end
                APPLY: begin
                    dly_tap   <= best_tap;
                    dly_ld    <= 1'b1;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iserdes_rdlvl_seq.sv
// Directed bench for iserdes_rdlvl_seq with a tap-dependent IDELAY/ISERDES model.
// Expectations adapt to ISERDES_RDLVL_INV_RETRY_EN where the retry changes the outcome.
module tb_iserdes_rdlvl_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] dout;
    logic [4:0] dly_tap;
    logic       dly_ld;
    logic       inv_clk_div;
    logic       busy;
    logic       done;
    logic       fail;
    logic [4:0] best_tap;
    logic [5:0] win_len;

    int checks = 0;
    int errors = 0;

    // Delay-line model: remembers the last loaded tap and the cycles since that load.
    logic [31:0] pass0 = '0;
    logic [31:0] pass1 = '0;
    logic        glitch_en = 1'b0;
    logic [4:0]  model_tap = '0;
    int unsigned ld_age = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dly_ld) begin
            model_tap <= dly_tap;
            ld_age    <= 1;
        end else begin
            ld_age <= ld_age + 1;
        end
    end

    // Last sample of a tap lands 23 cycles after the load-strobe cycle (8 settle + 16 samples).
    assign dout = ((inv_clk_div ? pass1[model_tap] : pass0[model_tap]) &&
                   !(glitch_en && model_tap == 5'd15 && ld_age == 23)) ? 4'b0101 : 4'b0111;

    iserdes_rdlvl_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dout        (dout),
        .dly_tap     (dly_tap),
        .dly_ld      (dly_ld),
        .inv_clk_div (inv_clk_div),
        .busy        (busy),
        .done        (done),
        .fail        (fail),
        .best_tap    (best_tap),
        .win_len     (win_len)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_dly_tap"}, dly_tap, 0);
        check({tag, "_dly_ld"}, dly_ld, 0);
        check({tag, "_inv"}, inv_clk_div, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_fail"}, fail, 0);
        check({tag, "_best_tap"}, best_tap, 0);
        check({tag, "_win_len"}, win_len, 0);
    endtask

    // Runs one calibration from a start pulse; returns at the negedge where done/fail is first seen.
    task automatic run_cal(input string tag, input logic [31:0] p0, input logic [31:0] p1,
                           input bit glitch, input bit poke, output int busy_cyc);
        logic prev_ld;
        int   ld_bad;
        bit   finished;
        pass0     = p0;
        pass1     = p1;
        glitch_en = glitch;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        busy_cyc = 0;
        prev_ld  = 1'b0;
        ld_bad   = 0;
        finished = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (busy) busy_cyc++;
            if (dly_ld && prev_ld) ld_bad++;
            prev_ld = dly_ld;
            if (done || fail) begin
                finished = 1'b1;
                break;
            end
            start = poke && (i % 97 == 40);
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_finished"}, finished, 1);
        check({tag, "_ld_not_back_to_back"}, ld_bad, 0);
        $display("run %s: done=%0d fail=%0d inv=%0d best_tap=%0d win_len=%0d busy_cycles=%0d",
                 tag, done, fail, inv_clk_div, best_tap, win_len, busy_cyc);
    endtask

    task automatic expect_pass(input string tag, input int tap, input int len);
        check({tag, "_done"}, done, 1);
        check({tag, "_fail"}, fail, 0);
        check({tag, "_best_tap"}, best_tap, tap);
        check({tag, "_win_len"}, win_len, len);
        check({tag, "_final_ld"}, dly_ld, 1);
        check({tag, "_final_dly_tap"}, dly_tap, tap);
    endtask

    initial begin
        int  bc;
        bit  found;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_cal("win10_17", rng(10, 17), '0, 1'b0, 1'b0, bc);
        expect_pass("win10_17", 13, 8);
        check("win10_17_busy_cycles", bc, 866);
        check("win10_17_inv", inv_clk_div, 0);
        @(negedge clk);
        check("win10_17_ld_drops", dly_ld, 0);
        check("win10_17_done_sticky", done, 1);

        run_cal("two_win", rng(3, 5) | rng(20, 24), '0, 1'b0, 1'b0, bc);
        expect_pass("two_win", 22, 5);

        run_cal("tie_win", rng(2, 4) | rng(8, 10), '0, 1'b0, 1'b0, bc);
        expect_pass("tie_win", 3, 3);

        run_cal("edge_win", rng(27, 31), '0, 1'b0, 1'b0, bc);
        expect_pass("edge_win", 29, 5);

        run_cal("all_pass", 32'hFFFF_FFFF, '0, 1'b0, 1'b0, bc);
        expect_pass("all_pass", 15, 32);

        run_cal("none", '0, '0, 1'b0, 1'b0, bc);
        check("none_fail", fail, 1);
        check("none_done", done, 0);
        check("none_dly_tap", dly_tap, 0);
        check("none_final_ld", dly_ld, 1);
        check("none_win_len", win_len, 0);
`ifdef ISERDES_RDLVL_INV_RETRY_EN
        check("none_busy_cycles", bc, 1730);
        check("none_inv", inv_clk_div, 1);
`else
        check("none_busy_cycles", bc, 865);
        check("none_inv", inv_clk_div, 0);
`endif

        run_cal("inv_only", '0, rng(6, 9), 1'b0, 1'b0, bc);
`ifdef ISERDES_RDLVL_INV_RETRY_EN
        expect_pass("inv_only", 7, 4);
        check("inv_only_inv", inv_clk_div, 1);
`else
        check("inv_only_fail", fail, 1);
        check("inv_only_done", done, 0);
        check("inv_only_inv", inv_clk_div, 0);
`endif

        run_cal("poke_start", rng(10, 17), '0, 1'b0, 1'b1, bc);
        expect_pass("poke_start", 13, 8);
        check("poke_start_busy_cycles", bc, 866);
        check("poke_start_inv", inv_clk_div, 0);

        // Abort mid-SAMPLE at tap 12, then recalibrate from scratch.
        pass0 = rng(10, 17);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (model_tap == 5'd12 && ld_age == 15) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("abort_reached_tap12", found, 1);
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("abort");
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_still_idle", busy, 0);
        run_cal("after_abort", rng(10, 17), '0, 1'b0, 1'b0, bc);
        expect_pass("after_abort", 13, 8);
        check("after_abort_busy_cycles", bc, 866);

        run_cal("glitch15", rng(10, 20), '0, 1'b1, 1'b0, bc);
        expect_pass("glitch15", 12, 5);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
